fetch_line_ctrl: RTL and testbench



---
 rtl/fetch_line_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_line_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_ctrl.sv
// Fetch line buffer and single-outstanding I-cache miss controller.
// Holds one line, issues line requests on a miss, and drops responses killed by a flush.
package mmm_pkg;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned ILEN          = 32;
  localparam int unsigned OFFSET        = 2;
  localparam int unsigned ICACHE_OFFSET = 2;
  localparam int unsigned LINE_W        = ILEN << ICACHE_OFFSET;
  localparam int unsigned LINE_WORDS    = 1 << ICACHE_OFFSET;
endpackage

module fetch_line_ctrl
  import mmm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              pc_valid_i,
  input  logic              flush_i,
  input  logic              here_i,
  input  logic              will_be_here_i,
  output logic [XLEN-1:0]   line_pc_o,
  output logic              line_valid_o,
  output logic [XLEN-1:0]   prev_pc_o,
  output logic [ILEN-1:0]   instr_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic              ic_req_valid_o,
  input  logic              ic_req_ready_i,
  output logic [XLEN-1:0]   ic_addr_o,
  input  logic              ic_resp_valid_i,
  input  logic [LINE_W-1:0] ic_resp_data_i
);

  localparam int unsigned LO = ICACHE_OFFSET + OFFSET;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic                kill_q, kill_d;
  logic [XLEN-1:0]     prev_pc_q, prev_pc_d;
  logic [XLEN-1:0]     line_pc_q, line_pc_d;
  logic                line_valid_q, line_valid_d;
  logic [LINE_W-1:0]   line_data_q, line_data_d;
  logic                req_valid_q, req_valid_d;

  logic                trusted;
  logic                miss;
  logic [XLEN-1:0]     pc_aligned;
  logic [ICACHE_OFFSET-1:0] word_idx;

  // Byte-offset bits and the handshake from downstream do not affect this block.
  logic unused_inputs;
  assign unused_inputs = ^{pc_i[OFFSET-1:0], instr_ready_i};

  assign pc_aligned = {pc_i[XLEN-1:LO], {LO{1'b0}}};
  assign word_idx   = pc_i[LO-1:OFFSET];

  always_comb begin
    trusted      = (state_q != S_IDLE) & ~kill_q & will_be_here_i;
    miss         = pc_valid_i & ~here_i & ~flush_i & ~trusted;
    state_d      = state_q;
    kill_d       = kill_q;
    prev_pc_d    = prev_pc_q;
    line_pc_d    = line_pc_q;
    line_valid_d = line_valid_q & ~flush_i;
    line_data_d  = line_data_q;

    case (state_q)
      S_IDLE: begin
        if (miss) begin
          prev_pc_d = pc_aligned;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (flush_i) kill_d = 1'b1;
        if (ic_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ic_resp_valid_i) begin
          state_d = S_IDLE;
          if (kill_q | flush_i) begin
            kill_d = 1'b0;
          end else begin
            line_data_d  = ic_resp_data_i;
            line_pc_d    = prev_pc_q;
            line_valid_d = 1'b1;
          end
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      kill_q       <= 1'b0;
      prev_pc_q    <= '0;
      line_pc_q    <= '0;
      line_valid_q <= 1'b0;
      line_data_q  <= '0;
      req_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      prev_pc_q    <= prev_pc_d;
      line_pc_q    <= line_pc_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
      req_valid_q  <= req_valid_d;
    end
  end

  always_comb begin
    instr_o = '0;
    for (int unsigned w = 0; w < LINE_WORDS; w++) begin
      if (word_idx == ICACHE_OFFSET'(w)) instr_o = line_data_q[w*ILEN +: ILEN];
    end
  end

  assign instr_valid_o  = pc_valid_i & here_i & ~flush_i & ~rst_i;
  assign line_pc_o      = line_pc_q;
  assign line_valid_o   = line_valid_q;
  assign prev_pc_o      = prev_pc_q;
  assign ic_req_valid_o = req_valid_q;
  assign ic_addr_o      = prev_pc_q;

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// Testbench for fetch_line_ctrl: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_fetch_line_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  pc_i;
  logic         pc_valid_i, flush_i, here_i, will_be_here_i;
  logic [31:0]  line_pc_o, prev_pc_o, instr_o, ic_addr_o;
  logic         line_valid_o, instr_valid_o, ic_req_valid_o;
  logic         instr_ready_i, ic_req_ready_i, ic_resp_valid_i;
  logic [127:0] ic_resp_data_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  fetch_line_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .flush_i(flush_i), .here_i(here_i), .will_be_here_i(will_be_here_i),
    .line_pc_o(line_pc_o), .line_valid_o(line_valid_o), .prev_pc_o(prev_pc_o),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .ic_req_valid_o(ic_req_valid_o), .ic_req_ready_i(ic_req_ready_i),
    .ic_addr_o(ic_addr_o), .ic_resp_valid_i(ic_resp_valid_i),
    .ic_resp_data_i(ic_resp_data_i)
  );

  localparam logic [127:0] D0 = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] D1 = 128'h00000004_00000003_00000002_00000001;

  typedef struct {
    logic [31:0]  pc;
    logic         pcv, flush, here, wbh, rdy, resp;
    logic [127:0] data;
    logic         eiv;
    logic [31:0]  einstr;
    logic         ereq;
    logic [31:0]  eaddr;
    logic         elv;
    logic [31:0]  elpc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic pcv, flush, here, wbh, rdy, resp,
                       input logic [127:0] data);
    pc_i = pc; pc_valid_i = pcv; flush_i = flush; here_i = here;
    will_be_here_i = wbh; ic_req_ready_i = rdy; ic_resp_valid_i = resp; ic_resp_data_i = data;
  endtask

  task automatic step(input logic [31:0] pc, input logic pcv, flush, here, wbh, rdy, resp,
                      input logic [127:0] data);
    @(negedge clk_i);
    drive(pc, pcv, flush, here, wbh, rdy, resp, data);
    #1;
  endtask

  // Reference model: request/line bookkeeping in transaction terms.
  logic         m_busy, m_acc, m_kill, m_lval;
  logic [31:0]  m_prev, m_lpc;
  logic [127:0] m_data;

  task automatic do_reset();
    rst_i = 1'b1;
    drive(32'h0, 0, 0, 0, 0, 0, 0, '0);
    m_busy = 0; m_acc = 0; m_kill = 0; m_lval = 0;
    m_prev = 0; m_lpc = 0; m_data = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic model_step();
    logic trusted, nl;
    trusted = m_busy && !m_kill && will_be_here_i;
    nl = m_lval && !flush_i;
    if (!m_busy) begin
      if (!flush_i && pc_valid_i && !here_i && !trusted) begin
        m_busy = 1; m_acc = 0; m_prev = pc_i & ~32'hF;
      end
    end else if (!m_acc) begin
      if (flush_i) m_kill = 1;
      if (ic_req_ready_i) m_acc = 1;
    end else begin
      if (ic_resp_valid_i) begin
        if (m_kill || flush_i) m_kill = 0;
        else begin m_data = ic_resp_data_i; m_lpc = m_prev; nl = 1; end
        m_busy = 0; m_acc = 0;
      end else if (flush_i) m_kill = 1;
    end
    m_lval = nl;
  endtask

  vec_t vec[15];

  initial begin
    instr_ready_i = 1'b1;
    vec[0]  = '{32'h100,1,0,0,0,0,0,'0, 0,32'h0,0,32'h0,  0,32'h0};
    vec[1]  = '{32'h100,1,0,0,1,1,0,'0, 0,32'h0,1,32'h100,0,32'h0};
    vec[2]  = '{32'h100,1,0,0,1,0,1,D0, 0,32'h0,0,32'h100,0,32'h0};
    vec[3]  = '{32'h100,1,0,1,0,0,0,'0, 1,32'hA,0,32'h100,1,32'h100};
    vec[4]  = '{32'h104,1,0,1,0,0,0,'0, 1,32'hB,0,32'h100,1,32'h100};
    vec[5]  = '{32'h108,1,0,1,0,0,0,'0, 1,32'hC,0,32'h100,1,32'h100};
    vec[6]  = '{32'h10C,1,0,1,0,0,0,'0, 1,32'hD,0,32'h100,1,32'h100};
    vec[7]  = '{32'h200,1,0,0,0,0,0,'0, 0,32'hA,0,32'h100,1,32'h100};
    vec[8]  = '{32'h200,1,0,0,1,0,0,'0, 0,32'hA,1,32'h200,1,32'h100};
    vec[9]  = '{32'h204,1,0,0,1,0,0,'0, 0,32'hB,1,32'h200,1,32'h100};
    vec[10] = '{32'h208,1,0,0,1,0,0,'0, 0,32'hC,1,32'h200,1,32'h100};
    vec[11] = '{32'h20C,1,0,0,1,1,0,'0, 0,32'hD,1,32'h200,1,32'h100};
    vec[12] = '{32'h204,1,0,0,1,0,0,'0, 0,32'hB,0,32'h200,1,32'h100};
    vec[13] = '{32'h204,1,0,0,1,0,1,D1, 0,32'hB,0,32'h200,1,32'h100};
    vec[14] = '{32'h204,1,0,1,0,0,0,'0, 1,32'h2,0,32'h200,1,32'h200};

    // Reset values, including instr_valid forced low while in reset.
    rst_i = 1'b1;
    drive(32'h104, 1, 0, 1, 0, 0, 0, '0);
    #2;
    chk("rst_instr_valid", {31'b0, instr_valid_o}, 32'h0);
    do_reset();
    #1;
    chk("rst_line_valid", {31'b0, line_valid_o}, 32'h0);
    chk("rst_line_pc", line_pc_o, 32'h0);
    chk("rst_prev_pc", prev_pc_o, 32'h0);
    chk("rst_req_valid", {31'b0, ic_req_valid_o}, 32'h0);
    chk("rst_addr", ic_addr_o, 32'h0);

    // Miss, load, sequential hits, back-pressure and in-flight wait.
    for (int i = 0; i < 15; i++) begin
      step(vec[i].pc, vec[i].pcv, vec[i].flush, vec[i].here, vec[i].wbh,
           vec[i].rdy, vec[i].resp, vec[i].data);
      chk($sformatf("vec%0d_instr_valid", i), {31'b0, instr_valid_o}, {31'b0, vec[i].eiv});
      chk($sformatf("vec%0d_instr", i), instr_o, vec[i].einstr);
      chk($sformatf("vec%0d_req_valid", i), {31'b0, ic_req_valid_o}, {31'b0, vec[i].ereq});
      chk($sformatf("vec%0d_addr", i), ic_addr_o, vec[i].eaddr);
      chk($sformatf("vec%0d_line_valid", i), {31'b0, line_valid_o}, {31'b0, vec[i].elv});
      chk($sformatf("vec%0d_line_pc", i), line_pc_o, vec[i].elpc);
    end

    // Flush during WAIT, response arrives later and is dropped.
    do_reset();
    step(32'h300, 1, 0, 0, 0, 0, 0, '0);
    step(32'h300, 1, 0, 0, 1, 1, 0, '0);
    chk("fw_req_valid", {31'b0, ic_req_valid_o}, 32'h1);
    chk("fw_addr", ic_addr_o, 32'h300);
    step(32'h300, 1, 1, 0, 1, 0, 0, '0);
    chk("fw_flush_iv", {31'b0, instr_valid_o}, 32'h0);
    step(32'h300, 1, 0, 0, 1, 0, 1, D0);
    step(32'h300, 1, 0, 0, 1, 0, 0, '0);
    chk("fw_line_valid", {31'b0, line_valid_o}, 32'h0);
    chk("fw_idle_no_req", {31'b0, ic_req_valid_o}, 32'h0);
    step(32'h300, 1, 0, 0, 0, 1, 0, '0);
    chk("fw_fresh_req", {31'b0, ic_req_valid_o}, 32'h1);
    chk("fw_fresh_addr", ic_addr_o, 32'h300);
    step(32'h300, 1, 0, 0, 1, 0, 1, D1);
    step(32'h308, 1, 0, 1, 0, 0, 0, '0);
    chk("fw_reload_lv", {31'b0, line_valid_o}, 32'h1);
    chk("fw_reload_instr", instr_o, 32'h3);

    // Flush in the same cycle as the response.
    do_reset();
    step(32'h300, 1, 0, 0, 0, 0, 0, '0);
    step(32'h300, 1, 0, 0, 1, 1, 0, '0);
    step(32'h300, 1, 1, 0, 1, 0, 1, D0);
    step(32'h300, 1, 0, 0, 0, 0, 0, '0);
    chk("fr_line_valid", {31'b0, line_valid_o}, 32'h0);
    chk("fr_instr_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("fr_req_idle", {31'b0, ic_req_valid_o}, 32'h0);
    step(32'h300, 1, 0, 0, 1, 1, 0, '0);
    chk("fr_new_req", {31'b0, ic_req_valid_o}, 32'h1);
    step(32'h300, 1, 0, 0, 1, 0, 1, D1);
    step(32'h300, 1, 0, 1, 0, 0, 0, '0);
    chk("fr_kill_cleared", {31'b0, line_valid_o}, 32'h1);
    chk("fr_instr", instr_o, 32'h1);

    // Flush coincident with request acceptance in REQ.
    do_reset();
    step(32'h400, 1, 0, 0, 0, 0, 0, '0);
    step(32'h400, 1, 1, 0, 1, 1, 0, '0);
    step(32'h400, 1, 0, 0, 1, 0, 0, '0);
    chk("fq_wait_no_req", {31'b0, ic_req_valid_o}, 32'h0);
    step(32'h400, 1, 0, 0, 1, 0, 1, D0);
    step(32'h400, 1, 0, 0, 0, 0, 0, '0);
    chk("fq_dropped", {31'b0, line_valid_o}, 32'h0);
    step(32'h400, 1, 0, 0, 0, 0, 0, '0);
    chk("fq_new_req", {31'b0, ic_req_valid_o}, 32'h1);

    // Asynchronous reset while in WAIT, late response ignored.
    do_reset();
    step(32'h100, 1, 0, 0, 0, 0, 0, '0);
    step(32'h100, 1, 0, 0, 1, 1, 0, '0);
    step(32'h100, 1, 0, 0, 1, 0, 1, D0);
    step(32'h200, 1, 0, 0, 0, 0, 0, '0);
    step(32'h200, 1, 0, 0, 1, 1, 0, '0);
    @(negedge clk_i);
    drive(32'h204, 1, 0, 1, 0, 0, 0, '0);
    #1;
    chk("ar_pre_line_valid", {31'b0, line_valid_o}, 32'h1);
    #1 rst_i = 1'b1;
    #1;
    chk("ar_line_valid", {31'b0, line_valid_o}, 32'h0);
    chk("ar_line_pc", line_pc_o, 32'h0);
    chk("ar_prev_pc", prev_pc_o, 32'h0);
    chk("ar_req_valid", {31'b0, ic_req_valid_o}, 32'h0);
    chk("ar_instr_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("ar_instr", instr_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(32'h204, 0, 0, 0, 0, 0, 1, D1);
    step(32'h204, 0, 0, 0, 0, 0, 0, '0);
    chk("ar_late_resp_lv", {31'b0, line_valid_o}, 32'h0);
    chk("ar_late_resp_lpc", line_pc_o, 32'h0);
    chk("ar_late_resp_instr", instr_o, 32'h0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0]  pc;
      logic         pcv, fl, hr, wb, rd, rs;
      logic [127:0] dat;
      pc  = (32'h100 * $urandom_range(1, 4)) + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      pcv = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      hr  = m_lval && ((pc & ~32'hF) == m_lpc);
      wb  = ((pc & ~32'hF) == m_prev) && !hr;
      rd  = $urandom_range(0, 1);
      rs  = m_acc ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 19) == 0);
      dat = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk_i);
      drive(pc, pcv, fl, hr, wb, rd, rs, dat);
      #1;
      chk("rnd_instr_valid", {31'b0, instr_valid_o}, {31'b0, pcv && hr && !fl});
      chk("rnd_instr", instr_o, m_data[32*pc[3:2] +: 32]);
      chk("rnd_req_valid", {31'b0, ic_req_valid_o}, {31'b0, m_busy && !m_acc});
      chk("rnd_addr", ic_addr_o, m_prev);
      chk("rnd_line_valid", {31'b0, line_valid_o}, {31'b0, m_lval});
      chk("rnd_line_pc", line_pc_o, m_lpc);
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
